// File: rtl/macram_pkg.sv
// macram_pkg: shared types and helpers for the RAM-backed multiply-accumulate bank.
//   state_t    sweep controller states (IDLE, MAC, CLR)
//   DEF_DEPTH  default number of lags/accumulators
//   sat_value  clamp value for a saturating accumulate of width w
package macram_pkg;

    typedef enum logic [1:0] {IDLE, MAC, CLR} state_t;

    localparam int DEF_DEPTH = 256;

    // Unsigned accumulates can only overflow upward because the product is non-negative.
    // Signed overflow direction follows the (common) sign of the two addends.
    function automatic logic [63:0] sat_value(input logic sgn, input logic neg, input int unsigned w);
        return !sgn ? ~64'd0 : neg ? 64'd1 << (w - 1) : (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/macram_sdp.sv
// macram_sdp: simple dual-port synchronous RAM, one write port and one registered read port.
//   clk      clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address, data appears on rdata_o one cycle later
//   rdata_o  registered read data
// Contents are not reset.
module macram_sdp #(
    parameter int W     = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    (* ramstyle = "no_rw_check" *) logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/mac_ram_bank.sv
// mac_ram_bank: DEPTH accumulators in one block RAM; each accepted sample sweeps acc[k] += a*b_k.
//   clk, rst_n            clock, asynchronous active-low reset
//   sin, a_in             sample strobe and fixed operand (accepted in IDLE)
//   b_in                  streamed operand, lag k sampled on sweep cycle k+1
//   clr                   clear all accumulators, sweep counter and flags (accepted in IDLE)
//   busy, done            sweep/clear in progress, pulse on the last write
//   rd_req, rd_addr       readout request (accepted in IDLE)
//   rd_valid, rd_data     readout result, two cycles after the request
//   sweep_cnt             completed sweeps since last clear
//   overrun, ovf          sticky: sample dropped while busy, accumulator overflow
// Build option: MACRAM_SAT_EN makes accumulation saturate instead of wrapping.
module mac_ram_bank
    import macram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sin,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        a_in,
    input  logic [DATA_W-1:0]        b_in,
    output logic                     busy,
    output logic                     done,
    input  logic                     rd_req,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     rd_valid,
    output logic [ACC_W-1:0]         rd_data,
    output logic [CNT_W-1:0]         sweep_cnt,
    output logic                     overrun,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = 2 * DATA_W;

    if (ACC_W < PW) begin : g_bad_acc_w
        $error("mac_ram_bank: ACC_W must be >= 2*DATA_W");
    end
    if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("mac_ram_bank: DEPTH must be a power of two >= 4");
    end

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, wa_q;
    logic              iss_q, v1_q, rd_pend_q, rd_valid_q, overrun_q, ovf_q;
    logic [DATA_W-1:0] a_q;
    logic [PW-1:0]     prod_q, prod_d;
    logic [ACC_W-1:0]  rd_data_q, rdata, prod_ext, acc_nx;
    logic [ACC_W:0]    sum;
    logic [CNT_W-1:0]  sweep_cnt_q;
    logic              idle, is_mac, is_clr, take_sin, take_clr, take_rd;
    logic              last_addr, mac_done, clr_done, s_ov, ov;

    assign idle      = state_q == IDLE;
    assign is_mac    = state_q == MAC;
    assign is_clr    = state_q == CLR;
    assign take_sin  = idle && sin;
    assign take_clr  = idle && clr && !sin;
    assign take_rd   = idle && rd_req && !sin && !clr;
    assign last_addr = addr_q == AW'(DEPTH - 1);
    // v1_q without iss_q means the product of the last lag is being written back.
    assign mac_done  = is_mac && v1_q && !iss_q;
    assign clr_done  = is_clr && last_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = take_sin ? MAC : take_clr ? CLR : (mac_done || clr_done) ? IDLE : state_q;
    end

    // Operands are widened before multiplying so the low PW bits hold the exact product.
    assign prod_d   = SIGNED != 0 ? PW'($signed(a_q)) * PW'($signed(b_in)) : PW'(a_q) * PW'(b_in);
    assign prod_ext = SIGNED != 0 ? ACC_W'($signed(prod_q)) : ACC_W'(prod_q);
    assign sum      = {1'b0, rdata} + {1'b0, prod_ext};
    assign s_ov     = (rdata[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != rdata[ACC_W-1]);
    assign ov       = SIGNED != 0 ? s_ov : sum[ACC_W];
`ifdef MACRAM_SAT_EN
    assign acc_nx   = ov ? ACC_W'(sat_value(SIGNED != 0, rdata[ACC_W-1], ACC_W)) : sum[ACC_W-1:0];
`else
    assign acc_nx   = sum[ACC_W-1:0];
`endif

    // The single read port serves the sweep in MAC and host readout otherwise.
    macram_sdp #(.W(ACC_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    ((is_mac && v1_q) || is_clr),
        .waddr_i (is_clr ? addr_q : wa_q),
        .wdata_i (is_clr ? '0 : acc_nx),
        .raddr_i (is_mac ? addr_q : rd_addr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wa_q        <= '0;
            iss_q       <= 1'b0;
            v1_q        <= 1'b0;
            a_q         <= '0;
            prod_q      <= '0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            sweep_cnt_q <= '0;
            overrun_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rd_pend_q  <= take_rd;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) rd_data_q <= rdata;
            v1_q <= is_mac && iss_q;
            if (!idle && sin) overrun_q <= 1'b1;
            if (take_sin) begin
                a_q    <= a_in;
                addr_q <= '0;
                iss_q  <= 1'b1;
            end
            if (take_clr) begin
                addr_q      <= '0;
                sweep_cnt_q <= '0;
                overrun_q   <= 1'b0;
                ovf_q       <= 1'b0;
            end
            // addr_q wraps back to 0 after the last lag, leaving it ready for the next sweep.
            if (is_mac && iss_q) begin
                prod_q <= prod_d;
                wa_q   <= addr_q;
                addr_q <= addr_q + 1'b1;
                iss_q  <= !last_addr;
            end
            if (is_clr) addr_q <= addr_q + 1'b1;
            if (is_mac && v1_q && ov) ovf_q <= 1'b1;
            if (mac_done) sweep_cnt_q <= sweep_cnt_q + 1'b1;
        end
    end

    assign busy      = !idle;
    assign done      = mac_done || clr_done;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign sweep_cnt = sweep_cnt_q;
    assign overrun   = overrun_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_ram_bank.sv
// tb_mac_ram_bank: three bank configurations (unsigned/32, signed/32, unsigned/16) driven by the
// same stimulus and checked against a lag-array model every cycle, plus literal spot checks.
module tb_mac_ram_bank;

    localparam int DEPTH = 256;
    localparam logic [31:0] T5_EXP =
`ifdef MACRAM_SAT_EN
        32'h0000_FFFF;
`else
        32'h0000_FC02;
`endif

    logic clk = 0, rst_n, sin, clr, rd_req;
    logic [7:0] a_in, b_in, rd_addr;
    logic [2:0] busy, done, rdv, ovr, ovf;
    logic [2:0][31:0] rdd, scnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int AWG = (g == 2) ? 16 : 32;
        logic [AWG-1:0] rd_w;
        mac_ram_bank #(.DATA_W(8), .ACC_W(AWG), .DEPTH(DEPTH), .SIGNED(g == 1 ? 1 : 0), .CNT_W(32)) u_dut (
            .clk(clk), .rst_n(rst_n), .sin(sin), .clr(clr), .a_in(a_in), .b_in(b_in),
            .busy(busy[g]), .done(done[g]), .rd_req(rd_req), .rd_addr(rd_addr),
            .rd_valid(rdv[g]), .rd_data(rd_w), .sweep_cnt(scnt[g]), .overrun(ovr[g]), .ovf(ovf[g])
        );
        assign rdd[g] = 32'(rd_w);
    end

    int n_cmp = 0, n_bad = 0, cyc = 0, sin_cyc = 0, done_cyc = 0, rv_cnt = 0, rv0;
    bit chk_en = 0;

    // Model: rem counts the busy cycles still to come; accumulators updated lag by lag.
    int rem = 0, lag = 0;
    bit mac_m = 0, rv1 = 0, rv2 = 0, ovr_m = 0;
    bit [2:0] ovf_m = '0;
    logic [7:0] a_m = 0;
    logic [31:0] scnt_m = 0;
    logic [31:0] rq[3], rd_m[3];
    logic [31:0] macc[3][DEPTH];

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s u%0d t=%0t: got %0h expected %0h", nm, i, $time, got, exp);
        end
    endtask

    function automatic logic [32:0] step(input logic [31:0] acc, input logic [7:0] a, input logic [7:0] b, input int i);
        int w;
        bit sg, o;
        longint md, p, av, s, mx, mn;
        w  = (i == 2) ? 16 : 32;
        sg = (i == 1);
        md = longint'(1) << w;
        p  = sg ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
        av = longint'(acc) % md;
        if (sg && av >= md / 2) av -= md;
        s  = av + p;
        mx = sg ? md / 2 - 1 : md - 1;
        mn = sg ? -(md / 2) : 0;
        o  = (s > mx) || (s < mn);
`ifdef MACRAM_SAT_EN
        if (s > mx) s = mx;
        else if (s < mn) s = mn;
`endif
        s = ((s % md) + md) % md;
        return {o, 32'(s)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem = 0; mac_m = 0; lag = 0; rv1 = 0; rv2 = 0;
            scnt_m = 0; ovr_m = 0; ovf_m = '0;
            for (int i = 0; i < 3; i++) rd_m[i] = 0;
        end else begin
            rv2 = rv1;
            if (rv1) for (int i = 0; i < 3; i++) rd_m[i] = rq[i];
            rv1 = 0;
            if (rem == 0) begin
                if (sin) begin
                    rem = DEPTH + 1; mac_m = 1; lag = 0; a_m = a_in;
                end else if (clr) begin
                    rem = DEPTH; mac_m = 0; scnt_m = 0; ovr_m = 0; ovf_m = '0;
                    for (int i = 0; i < 3; i++) for (int k = 0; k < DEPTH; k++) macc[i][k] = 0;
                end else if (rd_req) begin
                    rv1 = 1;
                    for (int i = 0; i < 3; i++) rq[i] = macc[i][rd_addr];
                end
            end else begin
                if (sin) ovr_m = 1;
                if (mac_m && lag < DEPTH) begin
                    for (int i = 0; i < 3; i++) begin
                        logic [32:0] r;
                        r = step(macc[i][lag], a_m, b_in, i);
                        macc[i][lag] = r[31:0];
                        if (r[32]) ovf_m[i] = 1;
                    end
                    lag++;
                end
                if (rem == 1 && mac_m) scnt_m++;
                rem--;
            end
        end
    end

    always @(negedge clk) begin
        if (rdv[0]) rv_cnt++;
        if (done[0]) done_cyc = cyc;
        if (chk_en) for (int i = 0; i < 3; i++) begin
            chk("busy", i, 32'(busy[i]), 32'(rem > 0));
            chk("done", i, 32'(done[i]), 32'(rem == 1));
            chk("rd_valid", i, 32'(rdv[i]), 32'(rv2));
            chk("rd_data", i, rdd[i], rd_m[i]);
            chk("sweep_cnt", i, scnt[i], scnt_m);
            chk("overrun", i, 32'(ovr[i]), 32'(ovr_m));
            if (rem == 0) chk("ovf", i, 32'(ovf[i]), 32'(ovf_m[i]));
        end
    end

    task automatic wait_idle(input string nm, input int lim);
        int n = 0;
        while (busy[0] && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 0, 32'(busy[0]), 0);
    endtask

    task automatic do_clr();
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        wait_idle("clr_timeout", DEPTH + 8);
    endtask

    // mode 0: b = lag, 1: b = bc, 2: random. poke: cycle with sin/clr/rd_req pulsed. abort: cycle to assert reset.
    task automatic sweep(input logic [7:0] a, input int mode, input logic [7:0] bc, input int poke, input int abort);
        sin = 1; a_in = a; sin_cyc = cyc;
        for (int c = 1; c <= DEPTH; c++) begin
            @(posedge clk); #1;
            sin = (c == poke); clr = (c == poke); rd_req = (c == poke); rd_addr = 8'(c);
            b_in = mode == 0 ? 8'(c - 1) : mode == 1 ? bc : 8'($urandom);
            if (c == abort) begin
                rst_n = 0;
                break;
            end
        end
        if (abort == 0) begin
            @(posedge clk); #1;
            sin = 0; clr = 0; rd_req = 0; b_in = 0;
            @(posedge clk); #1;
            wait_idle("sweep_timeout", 8);
        end else begin
            sin = 0; clr = 0; rd_req = 0; b_in = 0;
        end
    endtask

    task automatic rd_chk(input int k, input int i, input logic [31:0] exp);
        rd_req = 1; rd_addr = 8'(k);
        @(posedge clk); #1;
        rd_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rd_valid_lat", i, 32'(rdv[i]), 1);
        chk("rd_val", i, rdd[i], exp);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1; sin = 0; clr = 0; rd_req = 0; a_in = 0; b_in = 0; rd_addr = 0;
        #3 rst_n = 0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_cnt", 0, scnt[0], 0);
        chk("rst_busy", 0, 32'(busy[0]), 0);
        chk("rst_rdata", 0, rdd[0], 0);

        do_clr();
        rv0 = rv_cnt;
        for (int k = 0; k < DEPTH; k++) begin
            rd_req = 1; rd_addr = 8'(k);
            @(posedge clk); #1;
        end
        rd_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rd_count", 0, rv_cnt - rv0, 256);

        sweep(8'd3, 0, 0, 0, 0);
        chk("done_lat", 0, done_cyc - sin_cyc, 257);
        sweep(8'd3, 0, 0, 0, 0);
        chk("cnt2", 0, scnt[0], 2);
        rd_chk(100, 0, 600);
        rd_chk(255, 0, 1530);

        do_clr();
        sweep(8'hFE, 1, 8'd5, 0, 0);
        rd_chk(0, 1, 32'hFFFF_FFF6);
        rd_chk(255, 1, 32'hFFFF_FFF6);
        rd_chk(9, 0, 1270);

        do_clr();
        rv0 = rv_cnt;
        sweep(8'd7, 2, 0, 50, 0);
        chk("ovr_set", 0, 32'(ovr[0]), 1);
        chk("ovr_cnt", 0, scnt[0], 1);
        chk("ovr_norv", 0, rv_cnt - rv0, 0);
        do_clr();
        chk("ovr_clr", 0, 32'(ovr[0]), 0);

        for (int r = 0; r < 3; r++) begin
            sweep(8'($urandom), 2, 0, int'($urandom_range(1, DEPTH)), 0);
            for (int j = 0; j < 24; j++) begin
                rd_req = 1'($urandom); rd_addr = 8'($urandom);
                @(posedge clk); #1;
            end
            rd_req = 0;
            repeat (2) @(posedge clk);
            #1;
        end

        do_clr();
        sweep(8'hFF, 1, 8'hFF, 0, 0);
        sweep(8'hFF, 1, 8'hFF, 0, 0);
        rd_chk(7, 2, T5_EXP);
        chk("ovf16", 2, 32'(ovf[2]), 1);
        chk("ovf32", 0, 32'(ovf[0]), 0);
        rd_chk(7, 1, 2);

        sweep(8'd3, 0, 0, 0, 100);
        @(negedge clk);
        chk("abort_busy", 0, 32'(busy[0]), 0);
        chk("abort_cnt", 0, scnt[0], 0);
        chk("abort_ovf", 2, 32'(ovf[2]), 0);
        chk("abort_rdata", 2, rdd[2], 0);
        @(posedge clk); #1;
        rst_n = 1;
        do_clr();
        sweep(8'd1, 0, 0, 0, 0);
        rd_chk(77, 0, 77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
